// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, RV32 opcodes and ALU codes.
// Also holds the funct3 -> ALU map shared by R-type and I-type decode.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'b000,
        ST_ID   = 3'b001,
        ST_EX   = 3'b010,
        ST_MEM  = 3'b011,
        ST_WB   = 3'b100,
        ST_TRAP = 3'b111
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_ERR = 4'b1111;

    // allow_sub is cleared for I-type: ADDI has no subtract form even with funct7 bits set.
    function automatic logic [3:0] funct3_alu(input logic [2:0] f3, input logic alt,
                                              input logic allow_sub);
        logic [3:0] code;
        case (f3)
            3'b000:  code = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
            3'b111:  code = ALU_AND;
            3'b110:  code = ALU_OR;
            3'b100:  code = ALU_XOR;
            3'b001:  code = ALU_SLL;
            3'b101:  code = alt ? ALU_SRA : ALU_SRL;
            3'b010:  code = ALU_SLT;
            default: code = ALU_ERR;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_ctrl_dec.sv
// Combinational instruction-field -> ALU code decode plus illegal-instruction flag.
// Latency: zero cycles; backpressure: none (pure decode).
module multicycle_ctrl_alu_ctrl_dec
    import multicycle_ctrl_pkg::*;
#(
    parameter bit ENABLE_ITYPE = 1'b1
) (
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_ctrl,
    output logic       illegal
);

    logic alt;
    assign alt = (funct7 == F7_ALT);

    always_comb begin
        alu_ctrl = ALU_ERR;
        case (opcode)
            OP_LOAD, OP_STORE: alu_ctrl = ALU_ADD;
            OP_BRANCH:         alu_ctrl = ALU_SUB;
            OP_RTYPE:          alu_ctrl = funct3_alu(funct3, alt, 1'b1);
            OP_ITYPE: begin
                if (ENABLE_ITYPE) alu_ctrl = funct3_alu(funct3, alt, 1'b0);
            end
            default: ;
        endcase
        // Only BEQ/BNE are implemented; other branch funct3 values trap.
        illegal = (alu_ctrl == ALU_ERR) || ((opcode == OP_BRANCH) && (funct3[2:1] != 2'b00));
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM driving datapath strobes from a latched instruction register.
// Latency: 4 cycles R/I/branch (5 if MEM not skipped), 5+waits for LW/SW; MEM stalls on dMemReady and traps on timeout.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter bit SKIP_MEM     = 1'b1,
    parameter bit ENABLE_ITYPE = 1'b1,
    parameter int MEM_TIMEOUT  = 15,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        Zero,
    input  logic        dMemReady,
    output logic        loadPC,
    output logic        PCSrc,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemToReg,
    output logic        ALUSrc,
    output logic [3:0]  ALUCtrl,
    output logic        trap,
    output logic [2:0]  fsm_state
);

    // The count is 0 in the first MEM cycle, so MEM_TIMEOUT-1 marks the last allowed unanswered cycle.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    state_t            state_q, state_d;
    logic [31:0]       ir_q, ir_d;
    logic              zero_q, zero_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_load, is_store, is_mem, is_branch, is_rtype, is_itype;
    logic       is_beq, is_bne, uses_imm, illegal;
    logic [3:0] alu_ctrl;
    logic       unused_ir;

    assign opcode    = ir_q[6:0];
    assign funct3    = ir_q[14:12];
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_mem    = is_load || is_store;
    assign is_branch = (opcode == OP_BRANCH);
    assign is_rtype  = (opcode == OP_RTYPE);
    assign is_itype  = (opcode == OP_ITYPE);
    assign is_beq    = is_branch && (funct3 == 3'b000);
    assign is_bne    = is_branch && (funct3 == 3'b001);
    assign uses_imm  = is_mem || is_itype;
    assign unused_ir = ^{ir_q[24:15], ir_q[11:7]};

    multicycle_ctrl_alu_ctrl_dec #(
        .ENABLE_ITYPE (ENABLE_ITYPE)
    ) u_alu_ctrl_dec (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7   (ir_q[31:25]),
        .alu_ctrl (alu_ctrl),
        .illegal  (illegal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IF;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IF:  state_d = ST_ID;
            ST_ID:  state_d = illegal ? ST_TRAP : ST_EX;
            ST_EX:  state_d = (is_mem || !SKIP_MEM) ? ST_MEM : ST_WB;
            ST_MEM: begin
                // Ready beats timeout when both land in the same cycle.
                if (!is_mem || dMemReady)       state_d = ST_WB;
                else if (cnt_q == TIMEOUT_LAST) state_d = ST_TRAP;
            end
            ST_WB:   state_d = ST_IF;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir_q   <= '0;
            zero_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            ir_q   <= ir_d;
            zero_q <= zero_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        ir_d   = ir_q;
        zero_d = zero_q;
        cnt_d  = cnt_q;
        if (state_q == ST_IF) ir_d   = instr;
        if (state_q == ST_EX) zero_d = Zero;
        if (state_q != ST_MEM)                       cnt_d = '0;
        else if (!dMemReady && (cnt_q != CNT_MAX))   cnt_d = cnt_q + 1'b1;
    end

    always_comb begin
        loadPC   = 1'b0;
        PCSrc    = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemToReg = 1'b0;
        ALUSrc   = 1'b0;
        trap     = 1'b0;
        case (state_q)
            ST_EX: ALUSrc = uses_imm;
            ST_MEM: begin
                ALUSrc   = uses_imm;
                MemRead  = is_load;
                MemWrite = is_store;
            end
            ST_WB: begin
                loadPC   = 1'b1;
                RegWrite = is_rtype || is_itype || is_load;
                MemToReg = is_load;
                PCSrc    = (is_beq && zero_q) || (is_bne && !zero_q);
            end
            ST_TRAP: trap = 1'b1;
            default: ;
        endcase
    end

    assign ALUCtrl   = alu_ctrl;
    assign fsm_state = state_q;

endmodule
